// File: rtl/twowire_apb_arbiter_pkg.sv
// Shared definitions for the two-requester APB3 arbiter.
// Holds the FSM state encoding and the debug-protocol data width.
// Latency / backpressure: none (declarations only).
package twowire_apb_arbiter_pkg;

   // The debug protocol fixes the data path at 32 bits.
   localparam int W_DATA = 32;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_ACCESS = 2'd2
   } state_t;

endpackage

// File: rtl/twowire_rr_arb2.sv
// Two-way round-robin picker: on a tie the requester that did not win last time wins.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to sample gnt_idx.
//
// Ports:
//   req[1:0]  request vector, bit N = requester N
//   last      index of the most recently served requester
//   gnt_idx   index of the chosen requester (0 when nothing is requested)
//   any       at least one request present
module twowire_rr_arb2
   import twowire_apb_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic       gnt_idx,
   output logic       any
);

   always_comb begin
      any = |req;
      if (req == 2'b11) begin
         gnt_idx = ~last;
      end else begin
         // Single requester (or none): bit 1 alone selects index 1, anything else index 0.
         gnt_idx = req[1];
      end
   end

endmodule

// File: rtl/twowire_apb_arbiter.sv
// Shares one downstream APB3 bus between two upstream APB3 masters, round-robin.
// Latency: lone request sampled in idle completes 2 cycles later at best; 3 cycles per downstream transfer minimum.
// Backpressure: the loser sees pready=0 and stalls in its access phase; downstream wait states stall the granted master.
//
// Ports:
//   dck, drst_n          clock, asynchronous active-low reset
//   s0_*, s1_*           upstream APB3 completer ports (requester 0 / requester 1)
//   dst_*                downstream APB3 requester port, driven only from registered copies
//   grant                index of the current or last-granted requester (observability)
module twowire_apb_arbiter
   import twowire_apb_arbiter_pkg::*;
#(
   parameter int W_ADDR = 8,
   parameter int W_DATA = 32
) (
   input  logic              dck,
   input  logic              drst_n,

   input  logic [W_ADDR-1:0] s0_paddr,
   input  logic              s0_psel,
   input  logic              s0_penable,
   input  logic              s0_pwrite,
   input  logic [W_DATA-1:0] s0_pwdata,
   output logic              s0_pready,
   output logic              s0_pslverr,
   output logic [W_DATA-1:0] s0_prdata,

   input  logic [W_ADDR-1:0] s1_paddr,
   input  logic              s1_psel,
   input  logic              s1_penable,
   input  logic              s1_pwrite,
   input  logic [W_DATA-1:0] s1_pwdata,
   output logic              s1_pready,
   output logic              s1_pslverr,
   output logic [W_DATA-1:0] s1_prdata,

   output logic [W_ADDR-1:0] dst_paddr,
   output logic              dst_psel,
   output logic              dst_penable,
   output logic              dst_pwrite,
   output logic [W_DATA-1:0] dst_pwdata,
   input  logic              dst_pready,
   input  logic              dst_pslverr,
   input  logic [W_DATA-1:0] dst_prdata,

   output logic              grant
);

   // Elaboration-time parameter checks.
   generate
      if (W_DATA != twowire_apb_arbiter_pkg::W_DATA) begin : g_bad_wdata
         $error("twowire_apb_arbiter: W_DATA must be 32");
      end
      if ((W_ADDR < 8) || ((W_ADDR % 8) != 0)) begin : g_bad_waddr
         $error("twowire_apb_arbiter: W_ADDR must be a non-zero multiple of 8");
      end
   endgenerate

   state_t state;
   logic   last_grant;
   logic   win_idx;
   logic   win_any;

   twowire_rr_arb2 u_rr (
      .req     ({s1_psel, s0_psel}),
      .last    (last_grant),
      .gnt_idx (win_idx),
      .any     (win_any)
   );

   // Single FSM; every dst_* output is a register so downstream timing never
   // depends on upstream combinational paths. last_grant resets to 1 so that
   // requester 0 wins the first tie.
   always_ff @(posedge dck or negedge drst_n) begin
      if (!drst_n) begin
         state       <= S_IDLE;
         grant       <= 1'b0;
         last_grant  <= 1'b1;
         dst_paddr   <= '0;
         dst_psel    <= 1'b0;
         dst_penable <= 1'b0;
         dst_pwrite  <= 1'b0;
         dst_pwdata  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (win_any) begin
                  // Capture the winner's request; it stays frozen until completion.
                  dst_paddr   <= win_idx ? s1_paddr  : s0_paddr;
                  dst_pwrite  <= win_idx ? s1_pwrite : s0_pwrite;
                  dst_pwdata  <= win_idx ? s1_pwdata : s0_pwdata;
                  grant       <= win_idx;
                  dst_psel    <= 1'b1;
                  dst_penable <= 1'b0;
                  state       <= S_SETUP;
               end
            end
            S_SETUP: begin
               dst_penable <= 1'b1;
               state       <= S_ACCESS;
            end
            S_ACCESS: begin
               // Completes even if the granted master dropped psel; its
               // response is simply discarded by the pready gating below.
               if (dst_pready) begin
                  dst_psel    <= 1'b0;
                  dst_penable <= 1'b0;
                  last_grant  <= grant;
                  state       <= S_IDLE;
               end
            end
            default: begin
               dst_psel    <= 1'b0;
               dst_penable <= 1'b0;
               state       <= S_IDLE;
            end
         endcase
      end
   end

   // Responses are gated by the requester's own psel/penable so a master that
   // abandoned its transfer never sees a stray pready.
   assign s0_pready  = (state == S_ACCESS) && (grant == 1'b0) && dst_pready
                       && s0_psel && s0_penable;
   assign s1_pready  = (state == S_ACCESS) && (grant == 1'b1) && dst_pready
                       && s1_psel && s1_penable;
   assign s0_pslverr = s0_pready && dst_pslverr;
   assign s1_pslverr = s1_pready && dst_pslverr;
   assign s0_prdata  = dst_prdata;
   assign s1_prdata  = dst_prdata;

endmodule

// File: tb/tb_twowire_apb_arbiter.sv
// Directed bench for twowire_apb_arbiter: two APB masters driven by tasks,
// a downstream completer model with programmable wait states, and a transfer log.
module tb_twowire_apb_arbiter;

   logic        dck;
   logic        drst_n;
   logic [7:0]  s0_paddr, s1_paddr;
   logic        s0_psel, s0_penable, s0_pwrite;
   logic        s1_psel, s1_penable, s1_pwrite;
   logic [31:0] s0_pwdata, s1_pwdata;
   logic        s0_pready, s0_pslverr, s1_pready, s1_pslverr;
   logic [31:0] s0_prdata, s1_prdata;
   logic [7:0]  dst_paddr;
   logic        dst_psel, dst_penable, dst_pwrite;
   logic [31:0] dst_pwdata;
   logic        dst_pready, dst_pslverr;
   logic [31:0] dst_prdata;
   logic        grant;

   twowire_apb_arbiter #(.W_ADDR(8), .W_DATA(32)) dut (
      .dck(dck), .drst_n(drst_n),
      .s0_paddr(s0_paddr), .s0_psel(s0_psel), .s0_penable(s0_penable),
      .s0_pwrite(s0_pwrite), .s0_pwdata(s0_pwdata), .s0_pready(s0_pready),
      .s0_pslverr(s0_pslverr), .s0_prdata(s0_prdata),
      .s1_paddr(s1_paddr), .s1_psel(s1_psel), .s1_penable(s1_penable),
      .s1_pwrite(s1_pwrite), .s1_pwdata(s1_pwdata), .s1_pready(s1_pready),
      .s1_pslverr(s1_pslverr), .s1_prdata(s1_prdata),
      .dst_paddr(dst_paddr), .dst_psel(dst_psel), .dst_penable(dst_penable),
      .dst_pwrite(dst_pwrite), .dst_pwdata(dst_pwdata), .dst_pready(dst_pready),
      .dst_pslverr(dst_pslverr), .dst_prdata(dst_prdata),
      .grant(grant)
   );

   initial begin
      dck = 1'b0;
      forever #5 dck = ~dck;
   end

   int n_assert = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // ---------------- downstream completer model ----------------
   int          slv_wait     = 0;
   logic        slv_err      = 1'b0;
   logic        slv_use_addr = 1'b0;
   logic [31:0] slv_rdata    = 32'h0;
   int          wcnt         = 0;

   int          n_log = 0;
   logic        log_g [64];
   logic [7:0]  log_a [64];
   logic        log_w [64];
   logic [31:0] log_d [64];

   initial begin
      dst_pready  = 1'b0;
      dst_pslverr = 1'b0;
      dst_prdata  = 32'h0;
   end

   always @(posedge dck or negedge drst_n) begin
      if (!drst_n) begin
         dst_pready  = 1'b0;
         dst_pslverr = 1'b0;
         wcnt        = 0;
      end else begin
         #1;
         if (dst_psel && dst_penable && !dst_pready) begin
            if (wcnt >= slv_wait) begin
               dst_pready  = 1'b1;
               dst_pslverr = slv_err;
               dst_prdata  = slv_use_addr ? {16'hC0DE, 8'h00, dst_paddr} : slv_rdata;
               if (n_log < 64) begin
                  log_g[n_log] = grant;
                  log_a[n_log] = dst_paddr;
                  log_w[n_log] = dst_pwrite;
                  log_d[n_log] = dst_pwdata;
                  n_log++;
               end
            end else begin
               wcnt++;
            end
         end else begin
            dst_pready  = 1'b0;
            dst_pslverr = 1'b0;
            wcnt        = 0;
         end
      end
   end

   // ---------------- cycle monitor ----------------
   int pen_cyc = 0, s0_rdy = 0, s1_rdy = 0, s1_err = 0, err_viol = 0;

   always @(negedge dck) begin
      if (dst_penable) pen_cyc++;
      if (s0_pready) s0_rdy++;
      if (s1_pready) s1_rdy++;
      if (s1_pslverr) s1_err++;
      if ((s0_pslverr && !s0_pready) || (s1_pslverr && !s1_pready)) err_viol++;
   end

   task automatic mon_clear();
      pen_cyc = 0; s0_rdy = 0; s1_rdy = 0; s1_err = 0; err_viol = 0;
   endtask

   // ---------------- upstream master drivers ----------------
   task automatic set_m(input int m, input logic sel, input logic en,
                        input logic [7:0] a, input logic w, input logic [31:0] wd);
      if (m == 0) begin
         s0_psel = sel; s0_penable = en; s0_paddr = a; s0_pwrite = w; s0_pwdata = wd;
      end else begin
         s1_psel = sel; s1_penable = en; s1_paddr = a; s1_pwrite = w; s1_pwdata = wd;
      end
   endtask

   // One APB transfer; entered and left at posedge+1. cyc counts negedges
   // from the access phase start up to and including the pready sample.
   task automatic apb_xfer(input int m, input logic [7:0] a, input logic w,
                           input logic [31:0] wd, output logic [31:0] rd,
                           output logic er, output int cyc, output bit ok);
      rd = 32'h0; er = 1'b0; cyc = 0; ok = 1'b0;
      set_m(m, 1'b1, 1'b0, a, w, wd);
      @(posedge dck); #1;
      set_m(m, 1'b1, 1'b1, a, w, wd);
      for (int i = 0; i < 2000; i++) begin
         @(negedge dck);
         cyc++;
         if ((m == 0) ? s0_pready : s1_pready) begin
            rd = (m == 0) ? s0_prdata : s1_prdata;
            er = (m == 0) ? s0_pslverr : s1_pslverr;
            ok = 1'b1;
            break;
         end
      end
      @(posedge dck); #1;
      set_m(m, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0);
   endtask

   task automatic do_reset();
      drst_n = 1'b0;
      repeat (2) @(posedge dck);
      #1;
      drst_n = 1'b1;
   endtask

   // ---------------- directed sequence ----------------
   logic [31:0] rd0, rd1;
   logic        er0, er1;
   int          cy0, cy1;
   bit          ok0, ok1;
   int          bad0, bad1, base;
   logic [7:0]  a0, a1;

   initial begin
      drst_n = 1'b0;
      set_m(0, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0);
      set_m(1, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0);

      // Reset state
      repeat (2) @(negedge dck);
      chk("rst_dst_psel",    32'(dst_psel),    32'h0);
      chk("rst_dst_penable", 32'(dst_penable), 32'h0);
      chk("rst_dst_paddr",   32'(dst_paddr),   32'h0);
      chk("rst_dst_pwrite",  32'(dst_pwrite),  32'h0);
      chk("rst_dst_pwdata",  dst_pwdata,       32'h0);
      chk("rst_grant",       32'(grant),       32'h0);
      chk("rst_s0_pready",   32'(s0_pready),   32'h0);
      chk("rst_s1_pready",   32'(s1_pready),   32'h0);
      @(posedge dck); #1;
      drst_n = 1'b1;

      // Single read, one downstream wait state
      @(posedge dck); #1;
      slv_wait = 1; slv_rdata = 32'hDEADBEEF; slv_use_addr = 1'b0; slv_err = 1'b0;
      mon_clear();
      set_m(0, 1'b1, 1'b0, 8'h10, 1'b0, 32'h0);
      @(negedge dck);
      chk("rd_psel_idle", 32'(dst_psel), 32'h0);
      @(posedge dck); #1;
      set_m(0, 1'b1, 1'b1, 8'h10, 1'b0, 32'h0);
      @(negedge dck);
      chk("rd_setup_psel",    32'(dst_psel),    32'h1);
      chk("rd_setup_penable", 32'(dst_penable), 32'h0);
      chk("rd_setup_paddr",   32'(dst_paddr),   32'h10);
      chk("rd_setup_grant",   32'(grant),       32'h0);
      @(negedge dck);
      chk("rd_acc1_penable",  32'(dst_penable), 32'h1);
      chk("rd_acc1_s0_pready",32'(s0_pready),   32'h0);
      @(negedge dck);
      chk("rd_acc2_s0_pready",32'(s0_pready),   32'h1);
      chk("rd_acc2_prdata",   s0_prdata,        32'hDEADBEEF);
      chk("rd_acc2_pslverr",  32'(s0_pslverr),  32'h0);
      @(posedge dck); #1;
      set_m(0, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0);
      @(negedge dck);
      chk("rd_done_psel",   32'(dst_psel), 32'h0);
      chk("rd_pen_cycles",  32'(pen_cyc),  32'd2);
      chk("rd_s0_rdy_cnt",  32'(s0_rdy),   32'd1);
      chk("rd_s1_rdy_cnt",  32'(s1_rdy),   32'd0);

      // Simultaneous writes right after reset: s0 first, then s1
      do_reset();
      slv_wait = 0;
      base = n_log;
      fork
         apb_xfer(0, 8'h04, 1'b1, 32'h11111111, rd0, er0, cy0, ok0);
         apb_xfer(1, 8'h08, 1'b1, 32'h22222222, rd1, er1, cy1, ok1);
      join
      chk("wr_ok0", 32'(ok0), 32'h1);
      chk("wr_ok1", 32'(ok1), 32'h1);
      chk("wr_nlog", 32'(n_log - base), 32'd2);
      chk("wr0_grant", 32'(log_g[base]),   32'h0);
      chk("wr0_addr",  32'(log_a[base]),   32'h04);
      chk("wr0_write", 32'(log_w[base]),   32'h1);
      chk("wr0_data",  log_d[base],        32'h11111111);
      chk("wr1_grant", 32'(log_g[base+1]), 32'h1);
      chk("wr1_addr",  32'(log_a[base+1]), 32'h08);
      chk("wr1_write", 32'(log_w[base+1]), 32'h1);
      chk("wr1_data",  log_d[base+1],      32'h22222222);

      // Fairness: 8 back-to-back reads per master, grants must alternate
      slv_use_addr = 1'b1;
      base = n_log;
      bad0 = 0; bad1 = 0;
      fork
         begin
            for (int i = 0; i < 8; i++) begin
               a0 = 8'(32'h20 + i);
               apb_xfer(0, a0, 1'b0, 32'h0, rd0, er0, cy0, ok0);
               if (!ok0 || rd0 !== {16'hC0DE, 8'h00, a0}) bad0++;
            end
         end
         begin
            for (int j = 0; j < 8; j++) begin
               a1 = 8'(32'h40 + j);
               apb_xfer(1, a1, 1'b0, 32'h0, rd1, er1, cy1, ok1);
               if (!ok1 || rd1 !== {16'hC0DE, 8'h00, a1}) bad1++;
            end
         end
      join
      chk("fair_s0_bad", 32'(bad0), 32'd0);
      chk("fair_s1_bad", 32'(bad1), 32'd0);
      chk("fair_nlog", 32'(n_log - base), 32'd16);
      for (int k = 0; k < 16; k++) begin
         chk($sformatf("fair_grant%0d", k), 32'(log_g[base+k]), 32'(k % 2));
      end

      // Slave error on s1, then a clean s0 transfer
      slv_err = 1'b1;
      mon_clear();
      apb_xfer(1, 8'h30, 1'b1, 32'hCAFEF00D, rd1, er1, cy1, ok1);
      chk("err_ok",       32'(ok1),      32'h1);
      chk("err_s1_err",   32'(er1),      32'h1);
      chk("err_s1_cnt",   32'(s1_err),   32'd1);
      chk("err_viol",     32'(err_viol), 32'd0);
      slv_err = 1'b0;
      apb_xfer(0, 8'h34, 1'b0, 32'h0, rd0, er0, cy0, ok0);
      chk("err_next_ok",  32'(ok0), 32'h1);
      chk("err_next_err", 32'(er0), 32'h0);

      // Reset during a stalled access phase
      slv_wait = 1000;
      set_m(0, 1'b1, 1'b0, 8'h70, 1'b0, 32'h0);
      @(posedge dck); #1;
      set_m(0, 1'b1, 1'b1, 8'h70, 1'b0, 32'h0);
      for (int i = 0; i < 10; i++) begin
         @(negedge dck);
         if (dst_penable) break;
      end
      chk("ab_in_access", 32'(dst_penable), 32'h1);
      #2;
      drst_n = 1'b0;
      #1;
      chk("ab_psel_async",    32'(dst_psel),    32'h0);
      chk("ab_penable_async", 32'(dst_penable), 32'h0);
      set_m(0, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0);
      base = n_log;
      slv_wait = 0;
      repeat (2) @(negedge dck);
      drst_n = 1'b1;
      @(posedge dck); #1;
      apb_xfer(1, 8'h74, 1'b1, 32'h0BADF00D, rd1, er1, cy1, ok1);
      chk("ab_ok",      32'(ok1), 32'h1);
      chk("ab_latency", 32'(cy1), 32'd2);
      chk("ab_nlog",    32'(n_log - base), 32'd1);
      chk("ab_grant",   32'(log_g[base]), 32'h1);
      chk("ab_addr",    32'(log_a[base]), 32'h74);
      chk("ab_data",    log_d[base],      32'h0BADF00D);

      // s0 abandons its transfer mid access; s1 is pending behind it
      slv_wait = 2;
      mon_clear();
      base = n_log;
      fork
         begin
            set_m(0, 1'b1, 1'b0, 8'h50, 1'b0, 32'h0);
            @(posedge dck); #1;
            set_m(0, 1'b1, 1'b1, 8'h50, 1'b0, 32'h0);
            for (int i = 0; i < 10; i++) begin
               @(negedge dck);
               if (dst_penable) break;
            end
            @(posedge dck); #1;
            set_m(0, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0);
         end
         apb_xfer(1, 8'h60, 1'b0, 32'h0, rd1, er1, cy1, ok1);
      join
      chk("vio_s0_rdy",  32'(s0_rdy), 32'd0);
      chk("vio_s1_ok",   32'(ok1),    32'h1);
      chk("vio_s1_data", rd1,         32'hC0DE0060);
      chk("vio_nlog",    32'(n_log - base), 32'd2);
      chk("vio0_grant",  32'(log_g[base]),   32'h0);
      chk("vio0_addr",   32'(log_a[base]),   32'h50);
      chk("vio1_grant",  32'(log_g[base+1]), 32'h1);
      chk("vio1_addr",   32'(log_a[base+1]), 32'h60);

      repeat (2) @(posedge dck);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/twowire_apb_arbiter.md
Name: twowire_apb_arbiter

Overview:
- Two-requester APB3 arbiter that shares one downstream APB3 bus between two upstream masters.
- Typical use: the DTM core's downstream bus port and a second debug or bootstrap master reaching the same debug-module register space.
- Round-robin arbitration; the winner's access is re-issued downstream from registered copies, so downstream timing is independent of the upstream masters.

Parameters:
- W_ADDR, 8, address width of all ports; must be a multiple of 8, matching the DTM 8*(1+ASIZE) convention.
- W_DATA, 32, data width; fixed at 32 by the debug protocol and checked at elaboration.

Ports:
- dck  input  1  clock.
- drst_n  input  1  asynchronous active-low reset.
- s0_paddr  input  W_ADDR  requester 0 address.
- s0_psel  input  1  requester 0 select.
- s0_penable  input  1  requester 0 enable.
- s0_pwrite  input  1  requester 0 write.
- s0_pwdata  input  32  requester 0 write data.
- s0_pready  output  1  requester 0 ready.
- s0_pslverr  output  1  requester 0 error.
- s0_prdata  output  32  requester 0 read data.
- s1_*  same set as s0_*, for requester 1.
- dst_paddr  output  W_ADDR  downstream address.
- dst_psel  output  1  downstream select.
- dst_penable  output  1  downstream enable.
- dst_pwrite  output  1  downstream write.
- dst_pwdata  output  32  downstream write data.
- dst_pready  input  1  downstream ready.
- dst_pslverr  input  1  downstream error.
- dst_prdata  input  32  downstream read data.
- grant  output  1  index of the current or last-granted requester (observability only).

Behaviour:
- Reset (asynchronous on drst_n low): state=S_IDLE, all dst_* outputs 0, s*_pready=0, s*_pslverr=0, grant=0, last_grant=1 so that requester 0 wins the first tie.
- Request: sN_psel=1, in either the setup or the access phase.
- States:
  - S_IDLE: no downstream activity. If any request is present, choose the winner, register the winner's paddr/pwrite/pwdata into hold registers, set grant=winner, and go to S_SETUP. Otherwise stay in S_IDLE.
  - S_SETUP: dst_psel=1, dst_penable=0. Always goes to S_ACCESS.
  - S_ACCESS: dst_psel=1, dst_penable=1. When dst_pready=1, go to S_IDLE and set last_grant=grant.
- Winner selection:
  - Only one request present: that requester wins.
  - Both present: the requester != last_grant wins.
- dst_paddr, dst_pwrite and dst_pwdata come from the hold registers only. They stay stable from S_SETUP through completion, and reset to 0.
- Upstream response (combinational):
  - sN_pready = (state==S_ACCESS && grant==N && dst_pready && sN_psel && sN_penable).
  - sN_pslverr = sN_pready && dst_pslverr.
  - s0_prdata and s1_prdata = dst_prdata, broadcast to both.
- Non-granted requester: sees pready=0 and stalls in its access phase for as long as needed. It is never dropped.
- Latency: a lone request sampled in S_IDLE completes no earlier than 2 cycles later (S_SETUP, then S_ACCESS with dst_pready=1). Minimum downstream period is 3 cycles per transfer.
- Back-to-back: the completing requester's psel is still high in its completion cycle. S_IDLE on the next cycle therefore samples fresh psel values, and with both requesting the other requester wins (fairness).
- Protocol violation: a granted requester dropping psel mid-transfer.
  - The downstream transfer still runs to completion.
  - The response is discarded, because pready is gated by psel.
  - The arbiter then returns to S_IDLE. No lock-up.
- Downstream wait states: S_ACCESS holds indefinitely while dst_pready=0. There is no timeout.
- Reset mid-transfer: dst_psel drops asynchronously and all state returns to reset values.

Decomposition:
- Shared package/header holds the state encodings S_IDLE/S_SETUP/S_ACCESS (2 bits) and the W_DATA=32 constant used by the DTM core.
- One sub-module is natural: twowire_rr_arb2.
  - Purely combinational 2-way round-robin picker.
  - Inputs: req[1:0], last.
  - Outputs: gnt_idx, any.
  - Reused later for wider arbitration.

Test Plan:
- Single read: s0 reads addr 0x10, downstream returns 0xDEADBEEF with 1 wait state -> dst_psel seen 1 cycle after the s0 request. Exactly one dst_penable phase lasting 2 cycles. s0_prdata=0xDEADBEEF when s0_pready=1. s1_pready stays 0.
- Simultaneous requests after reset: s0 writes 0x11111111 to 0x04, s1 writes 0x22222222 to 0x08 in the same cycle -> s0 is served first, then s1. Downstream sees exactly those two writes in that order. grant goes 0 then 1.
- Fairness: s0 and s1 issue continuous back-to-back reads (8 each) -> downstream grants strictly alternate 0,1,0,1…. No requester waits for more than one foreign transfer.
- Error: s1 write, downstream returns pslverr=1 -> s1_pslverr=1 exactly in its pready cycle. The next s0 transfer has pslverr=0.
- Abort/reset: assert drst_n low during S_ACCESS with dst_pready=0 -> dst_psel/dst_penable are 0 immediately. After reset release, an s1 request is granted with normal latency and the prior transfer is not replayed.
- Upstream violation: s0 drops psel during S_ACCESS -> the downstream transfer completes, s0_pready never pulses, and a pending s1 request is then served normally.
